calc_operand_sequencer: RTL and testbench

CALC_OPERAND_SEQUENCER -- requirements
Module: calc_operand_sequencer

---
 rtl/calc_operand_sequencer_if.sv | 43 ++++
 rtl/calc_operand_sequencer.sv | 179 +++++++++++++++++
 tb/tb_calc_operand_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_operand_sequencer_if.sv
// Bus bundle for calc_operand_sequencer: upstream operand pairs, downstream
// ap_ctrl_hs core handshake, result stream and status.
interface calc_operand_sequencer_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  // operand pair input
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;

  // calculate core (ap_ctrl_hs)
  logic              calc_start;
  logic [DATA_W-1:0] calc_a;
  logic [DATA_W-1:0] calc_b;
  logic              calc_ready;
  logic              calc_done;
  logic [DATA_W-1:0] calc_return;

  // result output
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  // status
  logic [LVL_W-1:0]  fifo_level;
  logic              err_timeout;

  // sequencer side
  modport slave (
    input  s_valid, s_a, s_b, calc_ready, calc_done, calc_return, m_ready,
    output s_ready, calc_start, calc_a, calc_b, m_valid, m_data, fifo_level, err_timeout
  );

  // environment side
  modport master (
    output s_valid, s_a, s_b, calc_ready, calc_done, calc_return, m_ready,
    input  s_ready, calc_start, calc_a, calc_b, m_valid, m_data, fifo_level, err_timeout
  );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Buffers operand pairs in a small FIFO and feeds them one at a time to an
// ap_ctrl_hs calculate core, returning results in arrival order. A core that
// fails to finish within TIMEOUT cycles locks the block in ERR until reset.
module calc_operand_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  calc_operand_sequencer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t            state_q, state_d;

  logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;

  logic              calc_start_q, calc_start_d;
  logic [DATA_W-1:0] calc_a_q, calc_b_q;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push;
  logic              pop;
  logic              capture;
  logic              expired;

  // Accept only when a slot is free and the block has not locked up.
  assign bus.s_ready = (level_q < LVL_W'(FIFO_DEPTH)) && (state_q != S_ERR);
  assign push        = bus.s_valid && bus.s_ready;
  assign expired     = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign bus.calc_start  = calc_start_q;
  assign bus.calc_a      = calc_a_q;
  assign bus.calc_b      = calc_b_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.fifo_level  = level_q;
  assign bus.err_timeout = err_q;

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state, FIFO pop, result capture and next values of registered outputs.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    capture      = 1'b0;
    calc_start_d = calc_start_q;
    m_valid_d    = m_valid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop          = 1'b1;
          calc_start_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.calc_done) begin
          // ready and done together: skip WAIT and take the result now
          capture      = 1'b1;
          m_valid_d    = 1'b1;
          calc_start_d = 1'b0;
          state_d      = S_HOLD;
        end else if (expired) begin
          err_d        = 1'b1;
          calc_start_d = 1'b0;
          state_d      = S_ERR;
        end else if (bus.calc_ready) begin
          calc_start_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.calc_done) begin
          capture   = 1'b1;
          m_valid_d = 1'b1;
          state_d   = S_HOLD;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (level_q != '0) begin
            pop          = 1'b1;
            calc_start_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        m_valid_d    = 1'b0;
        calc_start_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= bus.s_a;
      mem_b[wr_ptr_q] <= bus.s_b;
    end
  end

  // Registered outputs, operand latch, result capture and timeout counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      calc_start_q <= 1'b0;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      calc_start_q <= calc_start_d;
      m_valid_q    <= m_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      if (pop) begin
        calc_a_q <= mem_a[rd_ptr_q];
        calc_b_q <= mem_b[rd_ptr_q];
      end
      if (capture) m_data_q <= bus.calc_return;
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a behavioural ap_ctrl_hs
// core that returns a+b.
module tb_calc_operand_sequencer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 255;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] results [$];

  calc_operand_sequencer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  calc_operand_sequencer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // Core model: samples calc_start when idle, raises ready/done after
  // rdy_dly/done_dly cycles (both 2 by default); core_hang suppresses both.
  bit                core_hang = 1'b0;
  int                rdy_dly   = 2;
  int                done_dly  = 2;
  logic              core_busy;
  int                core_cnt;
  logic              core_ready;
  logic              core_done;
  logic [DATA_W-1:0] core_ret;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      core_busy  <= 1'b0;
      core_cnt   <= 0;
      core_ready <= 1'b0;
      core_done  <= 1'b0;
      core_ret   <= '0;
    end else begin
      core_ready <= 1'b0;
      core_done  <= 1'b0;
      if (core_busy) begin
        core_cnt <= core_cnt + 1;
        if (!core_hang && (core_cnt + 1 == rdy_dly)) core_ready <= 1'b1;
        if (!core_hang && (core_cnt + 1 == done_dly)) begin
          core_done <= 1'b1;
          core_busy <= 1'b0;
        end
      end else if (bus.calc_start && !core_ready && !core_done) begin
        core_busy <= 1'b1;
        core_cnt  <= 0;
        core_ret  <= bus.calc_a + bus.calc_b;
      end
    end
  end

  assign bus.calc_ready  = core_ready;
  assign bus.calc_done   = core_done;
  assign bus.calc_return = core_ret;

  // Record the handshake due at the coming edge, then advance to the next negedge.
  task automatic tick();
    if (bus.m_valid && bus.m_ready) results.push_back(bus.m_data);
    @(negedge ap_clk);
  endtask

  // Offer one pair and return once it has been taken (ok=0 if never accepted).
  task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, output bit ok);
    int n = 0;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 50) begin
      tick();
      n++;
    end
    ok = bus.s_ready;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL reset_calc_start got %0d want 0", bus.calc_start); end
    checks++; if (bus.calc_a !== '0) begin errors++; $display("FAIL reset_calc_a got %0d want 0", bus.calc_a); end
    checks++; if (bus.calc_b !== '0) begin errors++; $display("FAIL reset_calc_b got %0d want 0", bus.calc_b); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0d want 0", bus.m_valid); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data got %0d want 0", bus.m_data); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %0d want 0", bus.err_timeout); end
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0d want 1", bus.s_ready); end
  endtask

  // Single pair (5,7): start two cycles after the push, exactly one result of 12.
  task automatic test_single();
    logic [DATA_W-1:0] got;
    results.delete();
    bus.m_ready = 1'b1;
    bus.s_a     = 32'd5;
    bus.s_b     = 32'd7;
    bus.s_valid = 1'b1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL single_s_ready got %0d want 1", bus.s_ready); end
    tick();
    bus.s_valid = 1'b0;
    checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL single_start_c1 got %0d want 0", bus.calc_start); end
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_c1 got %0d want 1", bus.fifo_level); end
    tick();
    checks++; if (bus.calc_start !== 1'b1) begin errors++; $display("FAIL single_start_c2 got %0d want 1", bus.calc_start); end
    checks++; if (bus.calc_a !== 32'd5) begin errors++; $display("FAIL single_calc_a got %0d want 5", bus.calc_a); end
    checks++; if (bus.calc_b !== 32'd7) begin errors++; $display("FAIL single_calc_b got %0d want 7", bus.calc_b); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_c2 got %0d want 0", bus.fifo_level); end
    for (int n = 0; n < 20 && !bus.m_valid; n++) tick();
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid got %0d want 1", bus.m_valid); end
    checks++; if (bus.m_data !== 32'd12) begin errors++; $display("FAIL single_m_data got %0d want 12", bus.m_data); end
    repeat (10) tick();
    checks++; if (results.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", results.size()); end
    got = (results.size() > 0) ? results[0] : '1;
    checks++; if (got !== 32'd12) begin errors++; $display("FAIL single_result got %0d want 12", got); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_end got %0d want 0", bus.fifo_level); end
  endtask

  // With one result parked in HOLD, four pushes fill the FIFO; release drains in order.
  task automatic test_fill();
    logic [DATA_W-1:0] exp_r [5];
    logic [DATA_W-1:0] got;
    bit ok;
    exp_r = '{32'd20, 32'd2, 32'd4, 32'd6, 32'd8};
    results.delete();
    bus.m_ready = 1'b0;
    push(32'd10, 32'd10, ok);
    for (int n = 0; n < 20 && !bus.m_valid; n++) tick();
    checks++; if (bus.m_data !== 32'd20) begin errors++; $display("FAIL fill_primer got %0d want 20", bus.m_data); end
    for (int i = 1; i <= 4; i++) begin
      push(DATA_W'(i), DATA_W'(i), ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_push%0d got %0d want 1", i, ok); end
    end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready_full got %0d want 0", bus.s_ready); end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL fill_level_full got %0d want 4", bus.fifo_level); end
    bus.m_ready = 1'b1;
    tick();
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL fill_level_pop got %0d want 3", bus.fifo_level); end
    for (int n = 0; n < 80 && results.size() < 5; n++) tick();
    repeat (5) tick();
    checks++; if (results.size() !== 5) begin errors++; $display("FAIL fill_count got %0d want 5", results.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < results.size()) ? results[i] : '1;
      checks++; if (got !== exp_r[i]) begin errors++; $display("FAIL fill_result%0d got %0d want %0d", i, got, exp_r[i]); end
    end
  endtask

  // A push offered while full is held off and taken once a pop frees a slot.
  task automatic test_full_push();
    logic [DATA_W-1:0] exp_r [6];
    logic [DATA_W-1:0] got;
    bit ok;
    exp_r = '{32'd101, 32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
    results.delete();
    bus.m_ready = 1'b0;
    push(32'd100, 32'd1, ok);
    for (int n = 0; n < 20 && !bus.m_valid; n++) tick();
    for (int i = 1; i <= 4; i++) push(DATA_W'(10 * i), DATA_W'(i), ok);
    bus.s_a     = 32'd50;
    bus.s_b     = 32'd5;
    bus.s_valid = 1'b1;
    repeat (3) tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %0d want 0", bus.s_ready); end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL full_level_held got %0d want 4", bus.fifo_level); end
    bus.m_ready = 1'b1;
    tick();
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL full_level_pop got %0d want 3", bus.fifo_level); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL full_s_ready_free got %0d want 1", bus.s_ready); end
    tick();
    bus.s_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL full_level_refill got %0d want 4", bus.fifo_level); end
    for (int n = 0; n < 100 && results.size() < 6; n++) tick();
    repeat (5) tick();
    checks++; if (results.size() !== 6) begin errors++; $display("FAIL full_count got %0d want 6", results.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < results.size()) ? results[i] : '1;
      checks++; if (got !== exp_r[i]) begin errors++; $display("FAIL full_result%0d got %0d want %0d", i, got, exp_r[i]); end
    end
  endtask

  // Reset while the core is in its done wait with two pairs still buffered.
  task automatic test_reset_midflight();
    int mv;
    bit ok;
    results.delete();
    bus.m_ready = 1'b1;
    push(32'd20, 32'd22, ok);
    for (int n = 0; n < 20 && results.size() < 1; n++) tick();
    checks++; if (bus.m_data !== 32'd42) begin errors++; $display("FAIL mid_prior_result got %0d want 42", bus.m_data); end
    rdy_dly  = 1;
    done_dly = 40;
    push(32'd1, 32'd1, ok);
    push(32'd2, 32'd2, ok);
    push(32'd3, 32'd3, ok);
    repeat (3) tick();
    checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL mid_start_in_wait got %0d want 0", bus.calc_start); end
    checks++; if (bus.fifo_level !== 3'd2) begin errors++; $display("FAIL mid_level_pre got %0d want 2", bus.fifo_level); end
    checks++; if (bus.calc_a !== 32'd1) begin errors++; $display("FAIL mid_calc_a_pre got %0d want 1", bus.calc_a); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (bus.calc_a !== '0) begin errors++; $display("FAIL mid_calc_a got %0d want 0", bus.calc_a); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %0d want 0", bus.m_valid); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL mid_m_data got %0d want 0", bus.m_data); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", bus.fifo_level); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    rdy_dly  = 2;
    done_dly = 2;
    mv = 0;
    repeat (20) begin
      if (bus.m_valid) mv++;
      tick();
    end
    checks++; if (mv !== 0) begin errors++; $display("FAIL mid_no_result got %0d want 0", mv); end
    checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL mid_no_start got %0d want 0", bus.calc_start); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready got %0d want 1", bus.s_ready); end
  endtask

  // Core never finishes: error exactly TIMEOUT cycles after ISSUE entry, then frozen.
  task automatic test_timeout();
    int n;
    bit ok;
    bus.m_ready = 1'b1;
    core_hang   = 1'b1;
    push(32'd9, 32'd9, ok);
    push(32'd8, 32'd8, ok);
    // calc_start rose at the edge that accepted the second pair
    checks++; if (bus.calc_start !== 1'b1) begin errors++; $display("FAIL to_start got %0d want 1", bus.calc_start); end
    n = 0;
    while (n < int'(TIMEOUT) + 20 && !bus.err_timeout) begin
      tick();
      n++;
    end
    checks++; if (n !== int'(TIMEOUT)) begin errors++; $display("FAIL to_latency got %0d want %0d", n, TIMEOUT); end
    checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %0d want 1", bus.err_timeout); end
    checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL to_start_drop got %0d want 0", bus.calc_start); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL to_s_ready got %0d want 0", bus.s_ready); end
    bus.s_a     = 32'd77;
    bus.s_b     = 32'd77;
    bus.s_valid = 1'b1;
    repeat (10) tick();
    bus.s_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL to_level_frozen got %0d want 1", bus.fifo_level); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL to_m_valid got %0d want 0", bus.m_valid); end
    checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %0d want 1", bus.err_timeout); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL to_s_ready_hold got %0d want 0", bus.s_ready); end
    core_hang = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_push();
    test_reset_midflight();
    test_timeout();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
